bus_arbiter: RTL



---
 rtl/bus_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Shared memory bus arbiter and wait-state sequencer for NUM_MASTERS
// requesters (CPU, OAM DMA, HDMA, ...). Fixed-priority or round-robin.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   m_req/m_we      per-master request and direction (1 = write)
//   m_addr/m_wdata  per-master address / write data, packed by index
//   m_ack           one-hot one-cycle completion pulse
//   m_rdata         shared read data, valid while m_ack is high
//   rd_en/wr_en     bus strobes, only active in ACCESS
//   addr_out        bus address
//   data_out        bus write data
//   data_in         bus read data, sampled on the last ACCESS cycle
module bus_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int WAIT_STATES = 0,
   parameter int RR_MODE     = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_MASTERS-1:0]      m_req,
   input  logic [NUM_MASTERS-1:0]      m_we,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
   output logic [NUM_MASTERS-1:0]      m_ack,
   output logic [DATA_W-1:0]           m_rdata,
   output logic                        rd_en,
   output logic                        wr_en,
   output logic [ADDR_W-1:0]           addr_out,
   output logic [DATA_W-1:0]           data_out,
   input  logic [DATA_W-1:0]           data_in
);

   localparam int IDX_W = $clog2(NUM_MASTERS);
   localparam logic [3:0] WS = 4'(WAIT_STATES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
   logic                gnt_we_q, gnt_we_d;
   logic [ADDR_W-1:0]   gnt_addr_q, gnt_addr_d;
   logic [DATA_W-1:0]   gnt_wdata_q, gnt_wdata_d;
   logic [3:0]          wait_cnt_q, wait_cnt_d;
   logic [IDX_W-1:0]    last_grant_q, last_grant_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                lo_found, hi_found, win_found;
   logic [IDX_W-1:0]    lo_idx, hi_idx, win_idx;

   // lo_*: lowest requester overall. hi_*: lowest requester above
   // last_grant. Round-robin prefers hi_* and wraps to lo_*.
   always_comb begin
      lo_found = 1'b0;
      lo_idx   = '0;
      hi_found = 1'b0;
      hi_idx   = '0;
      for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
         if (m_req[j]) begin
            lo_found = 1'b1;
            lo_idx   = IDX_W'(j);
            if (j > int'(last_grant_q)) begin
               hi_found = 1'b1;
               hi_idx   = IDX_W'(j);
            end
         end
      end
      win_found = lo_found;
      win_idx   = (RR_MODE != 0 && hi_found) ? hi_idx : lo_idx;
   end

   always_comb begin
      state_d      = state_q;
      gnt_idx_d    = gnt_idx_q;
      gnt_we_d     = gnt_we_q;
      gnt_addr_d   = gnt_addr_q;
      gnt_wdata_d  = gnt_wdata_q;
      wait_cnt_d   = wait_cnt_q;
      last_grant_d = last_grant_q;
      rdata_d      = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               gnt_idx_d    = win_idx;
               last_grant_d = win_idx;
               wait_cnt_d   = WS;
               state_d      = ACCESS;
               for (int j = 0; j < NUM_MASTERS; j++) begin
                  if (IDX_W'(j) == win_idx) begin
                     gnt_we_d    = m_we[j];
                     gnt_addr_d  = m_addr[j*ADDR_W +: ADDR_W];
                     gnt_wdata_d = m_wdata[j*DATA_W +: DATA_W];
                  end
               end
            end
         end
         ACCESS: begin
            if (wait_cnt_q == 4'd0) begin
               if (!gnt_we_q) rdata_d = data_in;
               state_d = DONE;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         gnt_idx_q    <= '0;
         gnt_we_q     <= 1'b0;
         gnt_addr_q   <= '0;
         gnt_wdata_q  <= '0;
         wait_cnt_q   <= 4'd0;
         last_grant_q <= LAST_IDX;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         gnt_idx_q    <= gnt_idx_d;
         gnt_we_q     <= gnt_we_d;
         gnt_addr_q   <= gnt_addr_d;
         gnt_wdata_q  <= gnt_wdata_d;
         wait_cnt_q   <= wait_cnt_d;
         last_grant_q <= last_grant_d;
         rdata_q      <= rdata_d;
      end
   end

   always_comb begin
      rd_en    = 1'b0;
      wr_en    = 1'b0;
      addr_out = '0;
      data_out = '0;
      m_ack    = '0;
      if (state_q == ACCESS) begin
         rd_en    = ~gnt_we_q;
         wr_en    = gnt_we_q;
         addr_out = gnt_addr_q;
         data_out = gnt_we_q ? gnt_wdata_q : '0;
      end
      if (state_q == DONE) m_ack = NUM_MASTERS'(1) << gnt_idx_q;
   end

   assign m_rdata = rdata_q;

endmodule
